// File: rtl/sram_mem_responder.sv
// Memory-side responder for the LC-3 datapath: turns edge-detected Mem_OE/Mem_WE requests into
// timed async-SRAM cycles. Define MEM_RESP_MMIO_EN to map IO_ADDR onto SW (read) / HEX_reg (write).
module sram_mem_responder #(
  parameter int unsigned SRAM_AW  = 20,
  parameter int unsigned DW       = 16,
  parameter int unsigned RD_WAIT  = 1,
  parameter int unsigned WR_PULSE = 2,
  parameter logic [15:0] IO_ADDR  = 16'hFFFF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Mem_OE,
  input  logic               Mem_WE,
  input  logic [15:0]        MAR,
  input  logic [DW-1:0]      MDR,
  output logic [DW-1:0]      Data_to_CPU,
  output logic               Data_valid,
  output logic               Busy,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  output logic               SRAM_CE_N,
  output logic               SRAM_OE_N,
  output logic               SRAM_WE_N,
  output logic               SRAM_UB_N,
  output logic               SRAM_LB_N,
  output logic [DW-1:0]      SRAM_DQ_out,
  output logic               SRAM_DQ_oe,
`ifdef MEM_RESP_MMIO_EN
  input  logic [DW-1:0]      SW,
  output logic [DW-1:0]      HEX_reg,
`endif
  input  logic [DW-1:0]      SRAM_DQ_in
);

  localparam int unsigned MaxCnt = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
  localparam int unsigned CntW   = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
`ifdef MEM_RESP_MMIO_EN
  localparam bit MmioEn = 1'b1;
`else
  localparam bit MmioEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle,
    StRdAct,
    StRdDone,
    StWrSetup,
    StWrPulse,
    StWrHold
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic            oe_q, we_q;
  logic            io_q;
  logic            rd_req, wr_req, is_io;

  assign rd_req = Mem_OE & ~oe_q;
  assign wr_req = Mem_WE & ~we_q;
  assign is_io  = MmioEn && (MAR == IO_ADDR);

  // An I/O access keeps every SRAM strobe high but walks the same state sequence.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      oe_q        <= 1'b0;
      we_q        <= 1'b0;
      io_q        <= 1'b0;
      Data_to_CPU <= '0;
      Data_valid  <= 1'b0;
      Busy        <= 1'b0;
      SRAM_ADDR   <= '0;
      SRAM_CE_N   <= 1'b1;
      SRAM_OE_N   <= 1'b1;
      SRAM_WE_N   <= 1'b1;
      SRAM_UB_N   <= 1'b1;
      SRAM_LB_N   <= 1'b1;
      SRAM_DQ_out <= '0;
      SRAM_DQ_oe  <= 1'b0;
`ifdef MEM_RESP_MMIO_EN
      HEX_reg     <= '0;
`endif
    end else begin
      oe_q       <= Mem_OE;
      we_q       <= Mem_WE;
      Data_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (wr_req) begin
            SRAM_ADDR   <= SRAM_AW'(MAR);
            SRAM_DQ_out <= MDR;
            io_q        <= is_io;
            SRAM_CE_N   <= is_io;
            SRAM_UB_N   <= is_io;
            SRAM_LB_N   <= is_io;
            SRAM_OE_N   <= 1'b1;
            SRAM_WE_N   <= 1'b1;
            SRAM_DQ_oe  <= ~is_io;
            Busy        <= 1'b1;
            state_q     <= StWrSetup;
          end else if (rd_req) begin
            SRAM_ADDR <= SRAM_AW'(MAR);
            io_q      <= is_io;
            SRAM_CE_N <= is_io;
            SRAM_OE_N <= is_io;
            SRAM_UB_N <= is_io;
            SRAM_LB_N <= is_io;
            cnt_q     <= CntW'(RD_WAIT - 1);
            Busy      <= 1'b1;
            state_q   <= StRdAct;
          end
        end
        StRdAct: begin
          if (cnt_q == '0) begin
`ifdef MEM_RESP_MMIO_EN
            Data_to_CPU <= io_q ? SW : SRAM_DQ_in;
`else
            Data_to_CPU <= SRAM_DQ_in;
`endif
            Data_valid <= 1'b1;
            SRAM_CE_N  <= 1'b1;
            SRAM_OE_N  <= 1'b1;
            SRAM_UB_N  <= 1'b1;
            SRAM_LB_N  <= 1'b1;
            state_q    <= StRdDone;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StRdDone: begin
          Busy    <= 1'b0;
          state_q <= StIdle;
        end
        StWrSetup: begin
          SRAM_WE_N <= io_q;
          cnt_q     <= CntW'(WR_PULSE - 1);
          state_q   <= StWrPulse;
        end
        StWrPulse: begin
          if (cnt_q == '0) begin
            SRAM_WE_N <= 1'b1;
            state_q   <= StWrHold;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StWrHold: begin
`ifdef MEM_RESP_MMIO_EN
          if (io_q) HEX_reg <= SRAM_DQ_out;
`endif
          SRAM_CE_N  <= 1'b1;
          SRAM_UB_N  <= 1'b1;
          SRAM_LB_N  <= 1'b1;
          SRAM_DQ_oe <= 1'b0;
          Busy       <= 1'b0;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_responder.sv
// Scoreboard bench for sram_mem_responder: directed requests push expected read data, a negedge
// monitor pops on every Data_valid and also tallies SRAM strobe activity.
module tb_sram_mem_responder;

  logic        clk, rst, mem_oe, mem_we;
  logic [15:0] mar, mdr, dtc, dq_out, dq_in;
  logic        dv, busy, ce_n, oe_n, we_n, ub_n, lb_n, dq_oe;
  logic [19:0] addr;
`ifdef MEM_RESP_MMIO_EN
  logic [15:0] sw, hex;
`endif

  logic [15:0] mem [256];
  logic [15:0] exp_q [$];
  int total, bad;
  int n_valid, n_access, n_we_low, n_oe_cyc, n_contend;
  int s_valid, s_access, s_we_low, s_oe_cyc;

  sram_mem_responder dut (
    .Clk        (clk),
    .Reset      (rst),
    .Mem_OE     (mem_oe),
    .Mem_WE     (mem_we),
    .MAR        (mar),
    .MDR        (mdr),
    .Data_to_CPU(dtc),
    .Data_valid (dv),
    .Busy       (busy),
    .SRAM_ADDR  (addr),
    .SRAM_CE_N  (ce_n),
    .SRAM_OE_N  (oe_n),
    .SRAM_WE_N  (we_n),
    .SRAM_UB_N  (ub_n),
    .SRAM_LB_N  (lb_n),
    .SRAM_DQ_out(dq_out),
    .SRAM_DQ_oe (dq_oe),
`ifdef MEM_RESP_MMIO_EN
    .SW         (sw),
    .HEX_reg    (hex),
`endif
    .SRAM_DQ_in (dq_in)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SRAM model: 256 words, location 0x10 preloaded with 0x1234 while reset is held.
  assign dq_in = (!ce_n && !oe_n) ? mem[addr[7:0]] : 16'hDEAD;
  always @(posedge clk) begin
    if (rst) mem[8'h10] <= 16'h1234;
    else if (!ce_n && !we_n) mem[addr[7:0]] <= dq_out;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic snap();
    s_valid  = n_valid;
    s_access = n_access;
    s_we_low = n_we_low;
    s_oe_cyc = n_oe_cyc;
  endtask

  task automatic do_read(input logic [15:0] a, input logic [15:0] e);
    exp_q.push_back(e);
    mar    = a;
    mem_oe = 1'b1;
    step();
    mem_oe = 1'b0;
    repeat (3) step();
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    mar    = a;
    mdr    = d;
    mem_we = 1'b1;
    step();
    mem_we = 1'b0;
    repeat (5) step();
  endtask

  // Monitor: scoreboard pop on Data_valid plus strobe/contention tallies.
  initial begin
    logic        prev_ce;
    logic [15:0] e;
    prev_ce = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!ce_n && prev_ce) n_access++;
        if (!we_n) n_we_low++;
        if (dq_oe) n_oe_cyc++;
        if (dq_oe && !oe_n) n_contend++;
        if (dv === 1'b1) begin
          n_valid++;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got data %h, required no pulse", dtc);
          end else begin
            e = exp_q.pop_front();
            chk("read_data", {16'h0, dtc}, {16'h0, e});
          end
        end
      end
      prev_ce = ce_n;
    end
  end

  initial begin
    rst    = 1'b1;
    mem_oe = 1'b0;
    mem_we = 1'b0;
    mar    = '0;
    mdr    = '0;
`ifdef MEM_RESP_MMIO_EN
    sw     = 16'h5A5A;
`endif
    repeat (3) step();
    chk("rst_strobes", {ce_n, oe_n, we_n, ub_n, lb_n}, 5'b11111);
    chk("rst_dq_oe", dq_oe, 1'b0);
    chk("rst_data", dtc, 16'h0);
    chk("rst_valid_busy", {dv, busy}, 2'b00);
    chk("rst_addr", addr, 20'h0);
    rst = 1'b0;
    step();

    // T1: read 0x0010, strobes low for exactly one cycle, data in the next.
    snap();
    exp_q.push_back(16'h1234);
    mar    = 16'h0010;
    mem_oe = 1'b1;
    step();
    mem_oe = 1'b0;
    chk("t1_act_strobes", {ce_n, oe_n, ub_n, lb_n, we_n}, 5'b00001);
    chk("t1_act_addr", addr, 20'h00010);
    chk("t1_act_busy_valid", {busy, dv}, 2'b10);
    step();
    chk("t1_done_strobes", {ce_n, oe_n}, 2'b11);
    chk("t1_done_valid", {busy, dv}, 2'b11);
    chk("t1_done_data", dtc, 16'h1234);
    step();
    chk("t1_idle", {busy, dv}, 2'b00);
    step();

    // T2: write 0x0020 <= 0xBEEF, then read it back.
    snap();
    mar    = 16'h0020;
    mdr    = 16'hBEEF;
    mem_we = 1'b1;
    step();
    mem_we = 1'b0;
    chk("t2_setup", {ce_n, oe_n, we_n, dq_oe, busy}, 5'b01111);
    chk("t2_setup_dq", dq_out, 16'hBEEF);
    step();
    chk("t2_pulse1", {ce_n, we_n, oe_n}, 3'b001);
    step();
    chk("t2_pulse2", {ce_n, we_n}, 2'b00);
    step();
    chk("t2_hold", {ce_n, we_n, dq_oe}, 3'b011);
    step();
    chk("t2_end", {ce_n, dq_oe, busy}, 3'b100);
    step();
    chk("t2_we_low_cycles", n_we_low - s_we_low, 2);
    chk("t2_dq_oe_cycles", n_oe_cyc - s_oe_cyc, 4);
    chk("t2_no_valid", n_valid - s_valid, 0);
    do_read(16'h0020, 16'hBEEF);

    // T3: Mem_OE held three cycles gives one access and one pulse.
    snap();
    exp_q.push_back(16'h1234);
    mar    = 16'h0010;
    mem_oe = 1'b1;
    repeat (3) step();
    mem_oe = 1'b0;
    repeat (3) step();
    chk("t3_accesses", n_access - s_access, 1);
    chk("t3_valids", n_valid - s_valid, 1);

    // T4: reset during the write pulse aborts the access.
    mar    = 16'h0040;
    mdr    = 16'h1111;
    mem_we = 1'b1;
    step();
    mem_we = 1'b0;
    step();
    chk("t4_in_pulse", {we_n, busy}, 2'b01);
    rst = 1'b1;
    step();
    chk("t4_abort_strobes", {we_n, ce_n, dq_oe}, 3'b110);
    chk("t4_abort_busy", busy, 1'b0);
    chk("t4_abort_data", dtc, 16'h0);
    rst = 1'b0;
    step();

    // T5: simultaneous OE/WE edges -> write only.
    snap();
    mar    = 16'h0030;
    mdr    = 16'h00FF;
    mem_oe = 1'b1;
    mem_we = 1'b1;
    step();
    mem_oe = 1'b0;
    mem_we = 1'b0;
    repeat (5) step();
    chk("t5_no_valid", n_valid - s_valid, 0);
    chk("t5_we_low_cycles", n_we_low - s_we_low, 2);
    do_read(16'h0030, 16'h00FF);

    // Read edge while busy with a write is dropped.
    snap();
    mar    = 16'h0050;
    mdr    = 16'h5555;
    mem_we = 1'b1;
    step();
    mem_we = 1'b0;
    mem_oe = 1'b1;
    step();
    mem_oe = 1'b0;
    repeat (5) step();
    chk("busy_drop_valid", n_valid - s_valid, 0);
    chk("busy_drop_access", n_access - s_access, 1);
    do_read(16'h0050, 16'h5555);

`ifdef MEM_RESP_MMIO_EN
    // T6: I/O address bypasses the SRAM.
    snap();
    do_write(16'hFFFF, 16'h00AB);
    chk("t6_hex", hex, 16'h00AB);
    do_read(16'hFFFF, 16'h5A5A);
    chk("t6_no_sram_access", n_access - s_access, 0);
    chk("t6_no_dq_oe", n_oe_cyc - s_oe_cyc, 0);
`endif

    do_write(16'h0060, 16'hC0DE);
    do_read(16'h0060, 16'hC0DE);

    chk("no_contention", n_contend, 0);
    chk("pending_reads", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
